// File: rtl/imp_moment_unit.sv
// First/second moment unit: accumulates N signed samples per frame and reports
// E[x], E[x^2] and the variance, with a selectable rounding mode and valid/ready handshakes.
`timescale 1ns/1ps
module imp_moment_unit #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int ROUND  = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [DATA_W-1:0] i_x,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [DATA_W:0]   o_ex,
    output logic [2*DATA_W-1:0]      o_ex2,
    output logic [2*DATA_W-1:0]      o_var
);

    localparam int S  = $clog2(N);
    localparam int SW = DATA_W + S;
    localparam int QW = 2*DATA_W + S;
    localparam int DW = 2*DATA_W + 2;

    localparam logic [S-1:0] LAST  = S'(N-1);
    localparam logic [SW:0]  RND_S = (SW+1)'((ROUND != 0) ? N/2 : 0);
    localparam logic [QW:0]  RND_Q = (QW+1)'((ROUND != 0) ? N/2 : 0);

    typedef enum logic [1:0] {ACC, MEAN, VAR, OUT} state_t;

    state_t                    state;
    logic [S-1:0]              count;
    logic signed [SW-1:0]      sum;
    logic [QW-1:0]             sq;
    logic signed [DATA_W-1:0]  ex_q;
    logic [2*DATA_W-1:0]       ex2_q;

    logic signed [2*DATA_W-1:0] xsq;
    logic signed [SW-1:0]       sum_next;
    logic [QW-1:0]              sq_next;
    logic [SW:0]                sum_rnd;
    logic [QW:0]                sq_rnd;
    logic signed [DW-1:0]       ex_ext;
    logic signed [DW-1:0]       exsq;
    logic signed [DW-1:0]       d;
    logic [2*DATA_W-1:0]        var_next;
    logic                       unused_bits;

    always_comb begin
        xsq      = i_x * i_x;
        sum_next = sum + {{S{i_x[DATA_W-1]}}, i_x};
        sq_next  = sq + {{S{1'b0}}, xsq};
        sum_rnd  = {sum[SW-1], sum} + RND_S;
        sq_rnd   = {1'b0, sq} + RND_Q;
        ex_ext   = {{(DW-DATA_W){ex_q[DATA_W-1]}}, ex_q};
        exsq     = ex_ext * ex_ext;
        d        = $signed({2'b00, ex2_q}) - exsq;
        var_next = d[DW-1] ? '0 : d[2*DATA_W-1:0];
    end

    // The top guard bits of the rounded sums and of d are provably zero or sign copies.
    assign unused_bits = &{1'b0, sum_rnd[SW], sq_rnd[QW], d[2*DATA_W]};

    assign o_ready = (state == ACC);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state   <= ACC;
            count   <= '0;
            sum     <= '0;
            sq      <= '0;
            ex_q    <= '0;
            ex2_q   <= '0;
            o_valid <= 1'b0;
            o_ex    <= '0;
            o_ex2   <= '0;
            o_var   <= '0;
        end else if (i_flush) begin
            state   <= ACC;
            count   <= '0;
            sum     <= '0;
            sq      <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (i_valid) begin
                        sum <= sum_next;
                        sq  <= sq_next;
                        if (count == LAST) begin
                            count <= '0;
                            state <= MEAN;
                        end else begin
                            count <= count + S'(1);
                        end
                    end
                end
                MEAN: begin
                    // Taking bits [S +: W] of the biased sum is the arithmetic shift right by S.
                    ex_q  <= sum_rnd[S +: DATA_W];
                    ex2_q <= sq_rnd[S +: 2*DATA_W];
                    state <= VAR;
                end
                VAR: begin
                    o_ex    <= {ex_q[DATA_W-1], ex_q};
                    o_ex2   <= ex2_q;
                    o_var   <= var_next;
                    o_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        sum     <= '0;
                        sq      <= '0;
                        state   <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_imp_moment_unit.sv
// Directed bench for imp_moment_unit: floor and round-half-up instances share stimulus and
// are checked every cycle against a frame-level arithmetic model plus hand-computed literals.
`timescale 1ns/1ps
module tb_imp_moment_unit;

    logic              clk;
    logic              rstn;
    logic              flush;
    logic              vld;
    logic signed [7:0] x;
    logic              rdy;

    logic              ready0, ready1, valid0, valid1;
    logic signed [8:0] ex0, ex1;
    logic [15:0]       ex20, ex21, var0, var1;

    imp_moment_unit #(.N(8), .DATA_W(8), .ROUND(0)) dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(vld), .o_ready(ready0),
        .i_x(x), .o_valid(valid0), .i_ready(rdy), .o_ex(ex0), .o_ex2(ex20), .o_var(var0)
    );

    imp_moment_unit #(.N(8), .DATA_W(8), .ROUND(1)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(vld), .o_ready(ready1),
        .i_x(x), .o_valid(valid1), .i_ready(rdy), .o_ex(ex1), .o_ex2(ex21), .o_var(var1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Floor division (SV '/' truncates toward zero).
    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q -= 1;
        return q;
    endfunction

    // Frame-level model: collect accepted samples, compute moments when the frame fills,
    // publish them two edges later, retire on downstream acceptance.
    int q[$];
    bit m_busy, m_valid;
    int m_timer;
    int p_ex[2], p_ex2[2], p_var[2];
    int m_ex[2], m_ex2[2], m_var[2];

    always @(posedge clk) begin
        if (!rstn) begin
            q.delete();
            m_busy = 0; m_valid = 0; m_timer = 0;
            for (int r = 0; r < 2; r++) begin
                m_ex[r] = 0; m_ex2[r] = 0; m_var[r] = 0;
            end
        end else if (flush) begin
            q.delete();
            m_busy = 0; m_valid = 0; m_timer = 0;
        end else if (!m_busy) begin
            if (vld) begin
                q.push_back(int'(x));
                if (q.size() == 8) begin
                    int s, s2, v, bias;
                    s = 0; s2 = 0;
                    foreach (q[i]) begin
                        s  += q[i];
                        s2 += q[i] * q[i];
                    end
                    for (int r = 0; r < 2; r++) begin
                        bias      = (r == 1) ? 4 : 0;
                        p_ex[r]   = fdiv(s + bias, 8);
                        p_ex2[r]  = (s2 + bias) / 8;
                        v         = p_ex2[r] - p_ex[r] * p_ex[r];
                        p_var[r]  = (v < 0) ? 0 : v;
                    end
                    q.delete();
                    m_busy  = 1;
                    m_timer = 2;
                end
            end
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 0;
                m_busy  = 0;
            end
        end else begin
            m_timer--;
            if (m_timer == 0) begin
                m_valid = 1;
                for (int r = 0; r < 2; r++) begin
                    m_ex[r] = p_ex[r]; m_ex2[r] = p_ex2[r]; m_var[r] = p_var[r];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready0", int'(ready0), int'(!m_busy));
            chk("valid0", int'(valid0), int'(m_valid));
            chk("ex0",    int'(ex0),    m_ex[0]);
            chk("ex2_0",  int'(ex20),   m_ex2[0]);
            chk("var0",   int'(var0),   m_var[0]);
            chk("ready1", int'(ready1), int'(!m_busy));
            chk("valid1", int'(valid1), int'(m_valid));
            chk("ex1",    int'(ex1),    m_ex[1]);
            chk("ex2_1",  int'(ex21),   m_ex2[1]);
            chk("var1",   int'(var1),   m_var[1]);
        end
    end

    int seq18[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int seqm1[8] = '{-1, 0, 0, 0, 0, 0, 0, 0};
    int seqlo[8] = '{-128, -128, -128, -128, -128, -128, -128, -128};
    int seqhi[8] = '{127, 127, 127, 127, 127, 127, 127, 127};
    int seq2[8]  = '{2, 2, 2, 2, 2, 2, 2, 2};

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int v);
        int n;
        vld = 1'b1;
        x   = 8'(v);
        n   = 0;
        while (!ready0 && n < 40) begin
            step();
            n++;
        end
        if (!ready0) chk("send_timeout", 0, 1);
        step();
        vld = 1'b0;
    endtask

    task automatic send_frame(input int s[8], input bit gaps);
        for (int i = 0; i < 8; i++) begin
            send(s[i]);
            if (gaps) repeat (1 + i % 3) step();
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid0 && lat < 30);
        if (!valid0) chk("result_timeout", 0, 1);
    endtask

    task automatic release_res();
        step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        @(negedge clk);
        chk("valid_drop", int'(valid0), 0);
    endtask

    task automatic expect_lit(input string n, input int a0, input int b0, input int c0,
                              input int a1, input int b1, input int c1);
        chk({n, "_ex_floor"},  int'(ex0),  a0);
        chk({n, "_ex2_floor"}, int'(ex20), b0);
        chk({n, "_var_floor"}, int'(var0), c0);
        chk({n, "_ex_round"},  int'(ex1),  a1);
        chk({n, "_ex2_round"}, int'(ex21), b1);
        chk({n, "_var_round"}, int'(var1), c1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish, limit 100000 ns reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rstn = 1'b0; flush = 1'b0; vld = 1'b0; x = '0; rdy = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_valid", int'(valid0), 0);
        chk("reset_ready", int'(ready0), 1);
        chk("reset_ex", int'(ex0), 0);

        send_frame(seq18, 1'b0);
        wait_valid(lat);
        chk("latency", lat, 3);
        expect_lit("ramp", 4, 25, 9, 5, 26, 1);
        release_res();

        send_frame(seqm1, 1'b0);
        wait_valid(lat);
        chk("neg1_ex_bits", int'($unsigned(ex0)), 'h1FF);
        expect_lit("neg1", -1, 0, 0, 0, 0, 0);
        release_res();

        send_frame(seqlo, 1'b0);
        wait_valid(lat);
        chk("min_ex_bits", int'($unsigned(ex0)), 'h180);
        expect_lit("min", -128, 16384, 0, -128, 16384, 0);
        release_res();

        send_frame(seqhi, 1'b0);
        wait_valid(lat);
        expect_lit("max", 127, 16129, 0, 127, 16129, 0);
        release_res();

        send_frame(seq18, 1'b1);
        wait_valid(lat);
        expect_lit("gaps", 4, 25, 9, 5, 26, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            vld = 1'b1;
            x   = 8'sd55;
            @(negedge clk);
            chk("hold_valid", int'(valid0), 1);
            chk("hold_ready", int'(ready0), 0);
            chk("hold_ex", int'(ex0), 4);
            chk("hold_var", int'(var0), 9);
        end
        step();
        vld = 1'b0;
        release_res();
        send_frame(seq2, 1'b0);
        wait_valid(lat);
        expect_lit("twos", 2, 4, 0, 2, 4, 0);
        release_res();

        for (int i = 0; i < 3; i++) send(100);
        flush = 1'b1;
        vld   = 1'b1;
        x     = 8'sd77;
        step();
        flush = 1'b0;
        vld   = 1'b0;
        send_frame(seq18, 1'b0);
        wait_valid(lat);
        expect_lit("flush", 4, 25, 9, 5, 26, 1);
        release_res();

        for (int i = 0; i < 3; i++) send(50);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", int'(valid0), 0);
        chk("rst_mid_ex", int'(ex0), 0);
        chk("rst_mid_var", int'(var0), 0);
        send_frame(seq18, 1'b0);
        wait_valid(lat);
        expect_lit("after_rst", 4, 25, 9, 5, 26, 1);
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(valid0), 0);
        chk("rst_out_ex2", int'(ex20), 0);
        chk("rst_out_var", int'(var0), 0);
        send_frame(seq2, 1'b0);
        wait_valid(lat);
        expect_lit("final", 2, 4, 0, 2, 4, 0);
        release_res();

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
